// File: rtl/audio_sample_feeder.sv
// Stereo sample FIFO feeding the codec serializer: one pair is popped per
// LRCK falling edge, volume-scaled, and held on the outputs until the next pop.
module audio_sample_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          iCLK_18_4,
   input  logic                          iRST_N,
   input  logic                          iAUD_LRCK,
   input  logic [DATA_WIDTH-1:0]         iSMP_L,
   input  logic [DATA_WIDTH-1:0]         iSMP_R,
   input  logic                          iSMP_VALID,
   output logic                          oSMP_READY,
   input  logic                          iFLUSH,
   input  logic [4:0]                    iVOL,
   output logic [DATA_WIDTH-1:0]         oAUD_extL,
   output logic [DATA_WIDTH-1:0]         oAUD_extR,
   output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
   output logic [7:0]                    oUNDERFLOW_CNT
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam int          PW        = DATA_WIDTH + 6;
   localparam logic [AW:0] LVL_FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [4:0]  VOL_UNITY = 5'd16;

   logic                        s1, s2, s3;
   logic                        pop_req;
   logic                        push_en;
   logic                        pop_en;
   logic                        underflow;
   logic [AW-1:0]               wr_ptr;
   logic [AW-1:0]               rd_ptr;
   logic [AW:0]                 level_q;
   logic [7:0]                  uf_cnt;
   logic [2*DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
   logic [2*DATA_WIDTH-1:0]     rd_q;
   logic                        pop_d;
   logic [4:0]                  vol_clamp;
   logic [4:0]                  vol_q;
   logic signed [PW-1:0]        smp_l_ext, smp_r_ext, vol_ext;
   logic signed [PW-1:0]        prod_l, prod_r;
   logic [DATA_WIDTH-1:0]       scaled_l, scaled_r;

   // LRCK synchronizer plus history flop; s3 resets low so a low LRCK at
   // reset release never looks like a falling edge.
   // NOTE: non-blocking assignments make each stage capture the previous
   // stage's pre-edge value; blocking would collapse the chain into one flop.
   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= iAUD_LRCK;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign pop_req    = s3 & ~s2;
   assign oSMP_READY = (level_q != LVL_FULL);
   assign push_en    = iSMP_VALID & oSMP_READY & ~iFLUSH;
   assign pop_en     = pop_req & (level_q != '0) & ~iFLUSH;
   assign underflow  = pop_req & (level_q == '0) & ~iFLUSH;
   assign vol_clamp  = (iVOL > VOL_UNITY) ? VOL_UNITY : iVOL;

   // Pointer, occupancy and underflow bookkeeping; flush wins over push/pop.
   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         uf_cnt  <= '0;
         pop_d   <= 1'b0;
         vol_q   <= '0;
      end else begin
         pop_d <= pop_en;
         if (iFLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
         end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) begin
               rd_ptr <= rd_ptr + 1'b1;
               vol_q  <= vol_clamp;
            end
            case ({push_en, pop_en})
               2'b10:   level_q <= level_q + 1'b1;
               2'b01:   level_q <= level_q - 1'b1;
               default: level_q <= level_q;
            endcase
            if (underflow && uf_cnt != 8'hFF) uf_cnt <= uf_cnt + 1'b1;
         end
      end
   end

   // NOTE: the storage array and its read register carry no reset so the
   // tools can map them onto a dual-port RAM; validity is tracked by level_q.
   always_ff @(posedge iCLK_18_4) begin
      if (push_en) mem[wr_ptr] <= {iSMP_L, iSMP_R};
      if (pop_en)  rd_q        <= mem[rd_ptr];
   end

   // Signed multiply wide enough that 0x8000 * 16 cannot overflow.
   always_comb begin
      smp_l_ext = {{6{rd_q[2*DATA_WIDTH-1]}}, rd_q[2*DATA_WIDTH-1:DATA_WIDTH]};
      smp_r_ext = {{6{rd_q[DATA_WIDTH-1]}},   rd_q[DATA_WIDTH-1:0]};
      vol_ext   = {{(PW-5){1'b0}}, vol_q};
      prod_l    = smp_l_ext * vol_ext;
      prod_r    = smp_r_ext * vol_ext;
      scaled_l  = DATA_WIDTH'(prod_l >>> 4);
      scaled_r  = DATA_WIDTH'(prod_r >>> 4);
   end

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         oAUD_extL <= '0;
         oAUD_extR <= '0;
      end else if (pop_d) begin
         oAUD_extL <= scaled_l;
         oAUD_extR <= scaled_r;
      end
   end

   assign oFIFO_LEVEL    = level_q;
   assign oUNDERFLOW_CNT = uf_cnt;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder: scoreboard of popped pairs
// plus a table of hand-computed volume-scaling vectors.
module tb_audio_sample_feeder;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int LW    = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          lrck = 1'b1;
   logic          valid = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] smp_l = '0;
   logic [DW-1:0] smp_r = '0;
   logic [4:0]    vol = 5'd16;
   logic          ready;
   logic [DW-1:0] out_l, out_r;
   logic [LW-1:0] level;
   logic [7:0]    uf;

   always #27 clk = ~clk;

   audio_sample_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .iCLK_18_4      (clk),
      .iRST_N         (rst_n),
      .iAUD_LRCK      (lrck),
      .iSMP_L         (smp_l),
      .iSMP_R         (smp_r),
      .iSMP_VALID     (valid),
      .oSMP_READY     (ready),
      .iFLUSH         (flush),
      .iVOL           (vol),
      .oAUD_extL      (out_l),
      .oAUD_extR      (out_r),
      .oFIFO_LEVEL    (level),
      .oUNDERFLOW_CNT (uf)
   );

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
   } pair_t;

   typedef struct {
      logic [4:0]  vol;
      logic [15:0] l, r, el, er;
   } vec_t;

   pair_t model_q[$];
   pair_t exp_q[$];
   pair_t model_out;
   int    model_uf;
   int    tests;
   int    fails;
   vec_t  vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_scale(input logic [15:0] s, input logic [4:0] v);
      int vi;
      int p;
      vi = (v > 5'd16) ? 16 : int'(v);
      p  = int'($signed(s)) * vi;
      p  = p >>> 4;
      return p[15:0];
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
      pair_t p;
      p.l = l;
      p.r = r;
      valid = 1'b1;
      smp_l = l;
      smp_r = r;
      cyc(1);
      valid = 1'b0;
      if (model_q.size() < DEPTH) model_q.push_back(p);
   endtask

   // One LRCK low period; optional push and/or flush in the pop cycle.
   task automatic lrck_fall(input bit push_at_pop, input bit flush_at_pop,
                            input logic [15:0] pl, input logic [15:0] pr);
      pair_t p, e;
      int    lvl_before;
      lrck = 1'b0;
      cyc(2);
      if (push_at_pop) begin
         valid = 1'b1;
         smp_l = pl;
         smp_r = pr;
      end
      flush      = flush_at_pop;
      lvl_before = model_q.size();
      cyc(1);
      valid = 1'b0;
      flush = 1'b0;
      if (flush_at_pop) begin
         model_q.delete();
      end else begin
         if (lvl_before > 0) begin
            p   = model_q.pop_front();
            e.l = model_scale(p.l, vol);
            e.r = model_scale(p.r, vol);
            exp_q.push_back(e);
         end else if (model_uf < 255) begin
            model_uf++;
         end
         if (push_at_pop && lvl_before < DEPTH) begin
            p.l = pl;
            p.r = pr;
            model_q.push_back(p);
         end
      end
      check("level_after_pop", 32'(level), 32'(model_q.size()));
      check("ready_after_pop", 32'(ready), 32'(model_q.size() != DEPTH));
      check("underflow_cnt", 32'(uf), 32'(model_uf));
      check("out_hold_before_e4", {out_l, out_r}, model_out);
      cyc(1);
      if (exp_q.size() > 0) model_out = exp_q.pop_front();
      check("out_at_e4", {out_l, out_r}, model_out);
      lrck = 1'b1;
      cyc(3);
   endtask

   initial begin
      #(54 * 60000);
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests     = 0;
      fails     = 0;
      model_uf  = 0;
      model_out = '0;

      vecs[0] = '{5'd16, 16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
      vecs[1] = '{5'd8,  16'h7FFF, 16'h8000, 16'h3FFF, 16'hC000};
      vecs[2] = '{5'd31, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
      vecs[3] = '{5'd0,  16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
      vecs[4] = '{5'd1,  16'h0010, 16'hFFF0, 16'h0001, 16'hFFFF};
      vecs[5] = '{5'd17, 16'h4000, 16'hC000, 16'h4000, 16'hC000};
      vecs[6] = '{5'd12, 16'h0100, 16'hFF00, 16'h00C0, 16'hFF40};

      // Reset state, checked while reset is still asserted.
      #3 rst_n = 1'b0;
      #5;
      check("rst_out_l", 32'(out_l), 32'h0);
      check("rst_out_r", 32'(out_r), 32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_uf", 32'(uf), 32'h0);
      check("rst_ready", 32'(ready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(4);

      // Three pairs, three LRCK falls at unity volume.
      vol = 5'd16;
      for (int k = 0; k < 3; k++) push_pair(16'h1000 + 16'(k), -(16'h1000 + 16'(k)));
      check("level_three", 32'(level), 32'd3);
      lrck_fall(0, 0, '0, '0);
      check("seq_pair0", {out_l, out_r}, {16'h1000, 16'hF000});
      lrck_fall(0, 0, '0, '0);
      check("seq_pair1", {out_l, out_r}, {16'h1001, 16'hEFFF});
      lrck_fall(0, 0, '0, '0);
      check("seq_pair2", {out_l, out_r}, {16'h1002, 16'hEFFE});
      check("level_drained", 32'(level), 32'd0);

      // Volume changes between pops leave held outputs untouched.
      vol = 5'd3;
      cyc(5);
      check("vol_change_hold", {out_l, out_r}, {16'h1002, 16'hEFFE});

      // Table of scaling vectors.
      for (int i = 0; i < 7; i++) begin
         vol = vecs[i].vol;
         push_pair(vecs[i].l, vecs[i].r);
         lrck_fall(0, 0, '0, '0);
         check($sformatf("scale_vec%0d", i), {out_l, out_r}, {vecs[i].el, vecs[i].er});
      end

      // Fill with VALID held high; the 17th pair must be refused.
      vol   = 5'd16;
      valid = 1'b1;
      for (int k = 0; k < 17; k++) begin
         pair_t p;
         bit    acc;
         p.l   = 16'h2000 + 16'(k);
         p.r   = 16'h3000 - 16'(k);
         smp_l = p.l;
         smp_r = p.r;
         acc   = (model_q.size() < DEPTH);
         cyc(1);
         if (acc) model_q.push_back(p);
         check("fill_ready", 32'(ready), 32'(model_q.size() != DEPTH));
      end
      valid = 1'b0;
      check("fill_level", 32'(level), 32'd16);
      // Pop at full with a coincident push: push refused, level 15.
      lrck_fall(1, 0, 16'h5555, 16'hAAAA);
      check("full_pop_level", 32'(level), 32'd15);
      while (model_q.size() > 0) lrck_fall(0, 0, '0, '0);
      lrck_fall(0, 0, '0, '0);

      // Coincident push and pop at level 5, then at level 0.
      for (int k = 0; k < 5; k++) push_pair(16'h0400 + 16'(k), 16'h0800 + 16'(k));
      lrck_fall(1, 0, 16'h0777, 16'h0888);
      check("coinc5_level", 32'(level), 32'd5);
      while (model_q.size() > 0) lrck_fall(0, 0, '0, '0);
      lrck_fall(1, 0, 16'h0123, 16'h0456);
      check("coinc0_level", 32'(level), 32'd1);
      lrck_fall(0, 0, '0, '0);
      check("coinc0_pair", {out_l, out_r}, {16'h0123, 16'h0456});

      // Flush concurrent with push and pop at level 4.
      for (int k = 0; k < 4; k++) push_pair(16'h0A00 + 16'(k), 16'h0B00 + 16'(k));
      lrck_fall(1, 1, 16'h0C00, 16'h0D00);
      check("flush_level", 32'(level), 32'd0);
      check("flush_out", {out_l, out_r}, {16'h0123, 16'h0456});
      push_pair(16'h0E0E, 16'hF1F1);
      lrck_fall(0, 0, '0, '0);
      check("post_flush_pair", {out_l, out_r}, {16'h0E0E, 16'hF1F1});

      // Underflow counter saturation.
      for (int k = 0; k < 300; k++) lrck_fall(0, 0, '0, '0);
      check("uf_saturated", 32'(uf), 32'd255);
      check("uf_out_hold", {out_l, out_r}, {16'h0E0E, 16'hF1F1});

      // Async reset mid-frame, released with LRCK low.
      push_pair(16'h1111, 16'h2222);
      push_pair(16'h3333, 16'h4444);
      lrck = 1'b0;
      cyc(1);
      #5 rst_n = 1'b0;
      #1;
      model_q.delete();
      exp_q.delete();
      model_out = '0;
      model_uf  = 0;
      check("arst_out", {out_l, out_r}, 32'h0);
      check("arst_level", 32'(level), 32'h0);
      check("arst_uf", 32'(uf), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1);
      check("arst_ready", 32'(ready), 32'h1);
      cyc(6);
      check("arst_no_pop_uf", 32'(uf), 32'h0);
      check("arst_no_pop_out", {out_l, out_r}, 32'h0);
      lrck = 1'b1;
      cyc(3);
      lrck_fall(0, 0, '0, '0);
      check("arst_discarded", 32'(uf), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
